// File: rtl/gol_pkg.sv
// Shared definitions for the Game-of-Life generation sequencer: FSM states,
// default widths and the length of the pattern-load sequence.
package gol_pkg;

  localparam int GOL_CNT_W    = 30;
  localparam int GOL_GEN_W    = 16;
  localparam int GOL_LOAD_LEN = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_COUNT = 3'd2,
    ST_ARMED = 3'd3,
    ST_TICK  = 3'd4
  } gol_state_t;

endpackage

// File: rtl/gol_period_timer.sv
// Generation interval timer. While start is held the timer runs; the period is
// captured in the first cycle of the run and done marks its last cycle.
module gol_period_timer
  import gol_pkg::*;
#(
  parameter int CNT_W = GOL_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] period,
  output logic             done
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] per_eff;
  logic             running;

  // A zero period would never expire, so it behaves as one cycle.
  assign per_eff = (period == '0) ? CNT_W'(1) : period;

  // The first cycle compares against the live period since per_q is not yet loaded.
  assign done = start & (running ? (cnt == (per_q - CNT_W'(1)))
                                 : (per_eff == CNT_W'(1)));

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      per_q   <= '0;
      running <= 1'b0;
    end else if (!start) begin
      cnt     <= '0;
      running <= 1'b0;
    end else if (!running) begin
      running <= 1'b1;
      per_q   <= per_eff;
      cnt     <= CNT_W'(1);
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gol_generation_sequencer.sv
// Sequences cell-grid generations (free-run, single step, pattern load).
// Define GOL_VBLANK_SYNC_EN to hold each generation tick until a vblank rising edge.
module gol_generation_sequencer
  import gol_pkg::*;
#(
  parameter int CNT_W = GOL_CNT_W,
  parameter int GEN_W = GOL_GEN_W
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             run,
  input  logic             step_req,
  input  logic             load_req,
  input  logic [CNT_W-1:0] period,
  input  logic             vblank,
  output logic             ca_tick,
  output logic             set_state,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy,
  output gol_state_t       state_dbg
);

  // step_req and load_req are single-cycle pulses acted on in the cycle they are
  // high; run is a level. All outputs are registered and change only on clk_in.
  localparam logic [1:0] LOAD_LAST = 2'(GOL_LOAD_LEN - 1);

  gol_state_t state;
  logic [1:0] load_cnt;
  logic       run_q;
  logic       run_fall;
  logic       timer_start;
  logic       timer_done;
  logic       tick_go;

  assign state_dbg   = state;
  assign run_fall    = run_q & ~run;
  assign timer_start = (state == ST_COUNT);

`ifdef GOL_VBLANK_SYNC_EN
  logic vblank_q;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) vblank_q <= 1'b0;
    else     vblank_q <= vblank;
  end

  // Only a fresh 0->1 transition qualifies; a level already high does not.
  assign tick_go = vblank & ~vblank_q;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign tick_go       = 1'b1;
`endif

  gol_period_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_in (clk_in),
    .rst    (rst),
    .start  (timer_start),
    .period (period),
    .done   (timer_done)
  );

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      load_cnt  <= '0;
      run_q     <= 1'b0;
      ca_tick   <= 1'b0;
      set_state <= 1'b0;
      gen_count <= '0;
      busy      <= 1'b0;
    end else begin
      run_q     <= run;
      ca_tick   <= 1'b0;
      set_state <= 1'b0;
      if (load_req) begin
        state     <= ST_LOAD;
        load_cnt  <= '0;
        set_state <= 1'b1;
        busy      <= 1'b1;
        gen_count <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (run) begin
              state <= ST_COUNT;
              busy  <= 1'b1;
            end else if (step_req) begin
              state <= ST_ARMED;
              busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            if (load_cnt == LOAD_LAST) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              load_cnt  <= load_cnt + 2'd1;
              set_state <= 1'b1;
              // The grid latches initial_state on the middle load cycle only.
              ca_tick   <= (load_cnt == 2'd0);
            end
          end
          ST_COUNT: begin
            if (!run) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (timer_done) begin
              state <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (run_fall) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (tick_go) begin
              state     <= ST_TICK;
              ca_tick   <= 1'b1;
              gen_count <= gen_count + GEN_W'(1);
            end
          end
          ST_TICK: begin
            if (run) begin
              state <= ST_COUNT;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gol_generation_sequencer.sv
// Directed, table-driven bench for gol_generation_sequencer (GEN_W=4 so the
// generation counter wrap is reachable).
module tb_gol_generation_sequencer;
  import gol_pkg::*;

  localparam int CW = 30;
  localparam int GW = 4;

  logic          clk_in;
  logic          rst;
  logic          run;
  logic          step_req;
  logic          load_req;
  logic [CW-1:0] period;
  logic          vblank;
  logic          ca_tick;
  logic          set_state;
  logic [GW-1:0] gen_count;
  logic          busy;
  gol_state_t    state_dbg;

  int n_vec = 0;
  int n_err = 0;

  gol_generation_sequencer #(.CNT_W(CW), .GEN_W(GW)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .run       (run),
    .step_req  (step_req),
    .load_req  (load_req),
    .period    (period),
    .vblank    (vblank),
    .ca_tick   (ca_tick),
    .set_state (set_state),
    .gen_count (gen_count),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk_in = 1'b0;
  always #10 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Each row: outputs expected at the start of a cycle, then inputs driven in it.
  typedef struct {
    int            grp;
    logic          e_tick;
    logic          e_set;
    logic [GW-1:0] e_gen;
    logic          e_busy;
    logic          run;
    logic          step;
    logic          load;
    logic [CW-1:0] per;
    logic          vb;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int grp, input logic et, input logic es, input int eg,
                     input logic eb, input logic r, input logic s, input logic l,
                     input int per, input logic vb);
    vec_t v;
    v.grp = grp; v.e_tick = et; v.e_set = es; v.e_gen = GW'(eg); v.e_busy = eb;
    v.run = r; v.step = s; v.load = l; v.per = CW'(per); v.vb = vb;
    vq.push_back(v);
  endtask

  // scoreboard compare: {ca_tick, set_state, gen_count, busy}
  task automatic check(input string nm, input int grp, input logic [GW+2:0] exp);
    logic [GW+2:0] act;
    act = {ca_tick, set_state, gen_count, busy};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s grp=%0d t=%0t tick/set/gen/busy got %b_%b_%h_%b required %b_%b_%h_%b",
               nm, grp, $time, act[GW+2], act[GW+1], act[GW:1], act[0],
               exp[GW+2], exp[GW+1], exp[GW:1], exp[0]);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic l,
                       input logic [CW-1:0] per, input logic vb);
    run = r; step_req = s; load_req = l; period = per; vblank = vb;
  endtask

  initial begin
    // --- shared groups (independent of vblank sync) ---
    // 3: load while ARMED
    add(3, 0,0,0,0, 0,1,0, 0,0);
    add(3, 0,0,0,1, 0,0,1, 0,0);
    add(3, 0,1,0,1, 0,0,0, 0,0);
    add(3, 1,1,0,1, 0,0,0, 0,0);
    add(3, 0,1,0,1, 0,0,0, 0,0);
    add(3, 0,0,0,0, 0,0,0, 0,0);
    // 4: load_req during LOAD restarts the sequence
    add(4, 0,0,0,0, 0,0,1, 0,0);
    add(4, 0,1,0,1, 0,0,0, 0,0);
    add(4, 1,1,0,1, 0,0,1, 0,0);
    add(4, 0,1,0,1, 0,0,0, 0,0);
    add(4, 1,1,0,1, 0,0,0, 0,0);
    add(4, 0,1,0,1, 0,0,0, 0,0);
    add(4, 0,0,0,0, 0,0,0, 0,0);
    // 5: run falls during COUNT -> IDLE, no tick
    add(5, 0,0,0,0, 1,0,0, 5,0);
    add(5, 0,0,0,1, 1,0,0, 5,0);
    add(5, 0,0,0,1, 0,0,0, 5,0);
    add(5, 0,0,0,0, 0,0,0, 5,0);
    add(5, 0,0,0,0, 0,0,0, 5,0);
`ifndef GOL_VBLANK_SYNC_EN
    // 1: period=4 free run, tick every 6 cycles, gen 1,2,3
    add(1, 0,0,0,0, 1,0,0, 4,0);
    for (int g = 1; g <= 3; g++) begin
      for (int k = 0; k < 4; k++) add(1, 0,0,g-1,1, 1,0,0, 4,0);
      add(1, 0,0,g-1,1, 1,0,0, 4,0);
      add(1, 1,0,g,1, (g < 3),0,0, 4,0);
    end
    add(1, 0,0,3,0, 0,0,0, 4,0);
    // 6: period=0 behaves as period=1
    add(6, 0,0,3,0, 1,0,0, 0,0);
    add(6, 0,0,3,1, 1,0,0, 0,0);
    add(6, 0,0,3,1, 1,0,0, 0,0);
    add(6, 1,0,4,1, 0,0,0, 0,0);
    add(6, 0,0,4,0, 0,0,0, 0,0);
    // 2: single step while paused
    add(2, 0,0,4,0, 0,1,0, 0,0);
    add(2, 0,0,4,1, 0,0,0, 0,0);
    add(2, 1,0,5,1, 0,0,0, 0,0);
    add(2, 0,0,5,0, 0,0,0, 0,0);
    // 7: gen_count wraps 15 -> 0
    add(7, 0,0,5,0, 1,0,0, 1,0);
    for (int t = 1; t <= 11; t++) begin
      add(7, 0,0,(4+t)%16,1, 1,0,0, 1,0);
      add(7, 0,0,(4+t)%16,1, 1,0,0, 1,0);
      add(7, 1,0,(5+t)%16,1, (t < 11),0,0, 1,0);
    end
    add(7, 0,0,0,0, 0,0,0, 1,0);
    // 8: period change mid-interval applies to the next interval
    add(8, 0,0,0,0, 1,0,0, 3,0);
    add(8, 0,0,0,1, 1,0,0, 3,0);
    add(8, 0,0,0,1, 1,0,0, 1,0);
    add(8, 0,0,0,1, 1,0,0, 1,0);
    add(8, 0,0,0,1, 1,0,0, 1,0);
    add(8, 1,0,1,1, 1,0,0, 1,0);
    add(8, 0,0,1,1, 1,0,0, 1,0);
    add(8, 0,0,1,1, 1,0,0, 1,0);
    add(8, 1,0,2,1, 0,0,0, 1,0);
    add(8, 0,0,2,0, 0,0,0, 1,0);
`else
    // 9: vblank high before ARMED must fall and rise again
    add(9, 0,0,0,0, 1,0,0, 2,1);
    add(9, 0,0,0,1, 1,0,0, 2,1);
    add(9, 0,0,0,1, 1,0,0, 2,1);
    add(9, 0,0,0,1, 1,0,0, 2,1);
    add(9, 0,0,0,1, 1,0,0, 2,1);
    add(9, 0,0,0,1, 1,0,0, 2,0);
    add(9, 0,0,0,1, 1,0,0, 2,0);
    add(9, 0,0,0,1, 1,0,0, 2,1);
    add(9, 1,0,1,1, 0,0,0, 2,1);
    add(9, 0,0,1,0, 0,0,0, 2,0);
`endif

    // reset state
    rst = 1'b1;
    drive(0, 0, 0, '0, 0);
    repeat (3) @(posedge clk_in);
    #1;
    check("reset", 0, '0);
    rst = 1'b0;

    // table application
    foreach (vq[i]) begin
      @(posedge clk_in);
      #1;
      check("vec", vq[i].grp, {vq[i].e_tick, vq[i].e_set, vq[i].e_gen, vq[i].e_busy});
      drive(vq[i].run, vq[i].step, vq[i].load, vq[i].per, vq[i].vb);
    end

    // asynchronous reset in the middle of LOAD
    @(posedge clk_in);
    #1;
    drive(0, 0, 1, CW'(4), 0);
    @(posedge clk_in);
    #1;
    drive(0, 0, 0, CW'(4), 0);
    check("load_entry", 10, {1'b0, 1'b1, GW'(0), 1'b1});
    #5;
    rst = 1'b1;
    #1;
    check("async_rst", 10, '0);
    run = 1'b1;
    #2;
    rst = 1'b0;
    // run held at release enters COUNT on the first edge
    @(posedge clk_in);
    #1;
    check("run_at_release", 11, {1'b0, 1'b0, GW'(0), 1'b1});
    n_vec++;
    if (state_dbg !== ST_COUNT) begin
      n_err++;
      $display("FAIL state_after_release got %0d required %0d", state_dbg, ST_COUNT);
    end
    run = 1'b0;
    @(posedge clk_in);
    #1;
    check("run_drop", 11, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
